alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two requesters: requester 0 is the core issue path and requester 1 is the auxiliary/debug sequencer.
- Uses round-robin arbitration with a valid/ready request handshake.
- Drives the ALU operand and command inputs, then registers the ALU outputs into a tagged response one cycle later.
- Supports a lock, so one requester can issue back-to-back dependent ops (multi-byte add/sub carry chains) without interleaving.

---
 rtl/alu_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between the core issue path (req 0) and
// the aux/debug sequencer (req 1). Round-robin grant with an optional lock
// for carry chains, bounded by a watchdog; ALU outputs come back as a
// registered, tagged response one cycle after the transfer.
//
// state    | meaning
// UNLOCKED | round-robin between valid requesters (rr_ptr_q breaks ties)
// LOCKED   | only owner_q may be granted; wd_q counts cycles spent locked
module alu_arbiter #(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 16,
  parameter int CW       = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ-1:0] req_lock,
  input  logic [3:0]      req_cmd0,
  input  logic [3:0]      req_cmd1,
  input  logic [7:0]      req_a0,
  input  logic [7:0]      req_a1,
  input  logic [7:0]      req_b0,
  input  logic [7:0]      req_b1,
  input  logic            req_sc0,
  input  logic            req_sc1,
  output logic [3:0]      alu_cmd,
  output logic [7:0]      alu_inA,
  output logic [7:0]      alu_inB,
  output logic            alu_sc_i,
  input  logic [7:0]      alu_rslt,
  input  logic            alu_sc_o,
  input  logic            alu_pari,
  input  logic            alu_one,
  output logic [NREQ-1:0] rsp_valid,
  output logic [7:0]      rsp_rslt,
  output logic            rsp_sc,
  output logic            rsp_pari,
  output logic            rsp_one,
  output logic [NREQ-1:0] lock_owner
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  // Last watchdog value before the lock is forcibly dropped.
  localparam logic [CW-1:0] WD_LAST = CW'(LOCK_MAX - 1);

  lock_state_t     state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rslt_q, rsp_rslt_d;
  logic            rsp_sc_q, rsp_sc_d;
  logic            rsp_pari_q, rsp_pari_d;
  logic            rsp_one_q, rsp_one_d;
  logic [3:0]      alu_cmd_q, alu_cmd_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic            alu_sc_q, alu_sc_d;

  logic [NREQ-1:0] grant;
  logic            gnt_id;
  logic            xfer;

  // Combinational grant from the registered lock state and round-robin pointer.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (state_q == LOCKED) begin
        if (req_valid[owner_q]) grant[owner_q] = 1'b1;
      end else if (req_valid == '1) begin
        grant[rr_ptr_q] = 1'b1;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign gnt_id = grant[1];
  assign xfer   = |grant;

  // Operand mux; without a transfer the ALU inputs keep their last values.
  always_comb begin
    alu_cmd_d = alu_cmd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sc_d  = alu_sc_q;
    if (xfer) begin
      alu_cmd_d = gnt_id ? req_cmd1 : req_cmd0;
      alu_a_d   = gnt_id ? req_a1   : req_a0;
      alu_b_d   = gnt_id ? req_b1   : req_b0;
      alu_sc_d  = gnt_id ? req_sc1  : req_sc0;
    end
  end

  // Lock FSM, watchdog and round-robin pointer next-state.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    if (xfer) rr_ptr_d = ~gnt_id;
    case (state_q)
      UNLOCKED: begin
        wd_d = '0;
        if (xfer && req_lock[gnt_id]) begin
          state_d = LOCKED;
          owner_d = gnt_id;
        end
      end
      LOCKED: begin
        if (wd_q == WD_LAST) begin
          // Forced release hands priority to the starved requester.
          state_d  = UNLOCKED;
          wd_d     = '0;
          rr_ptr_d = ~owner_q;
        end else if (!req_lock[owner_q]) begin
          // Only the owner can transfer here, so this covers both the
          // unlocking transfer and the idle lock drop.
          state_d = UNLOCKED;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      default: begin
        state_d = UNLOCKED;
        wd_d    = '0;
      end
    endcase
  end

  // Response capture: strobe for one cycle, data held between strobes.
  always_comb begin
    rsp_valid_d = grant;
    rsp_rslt_d  = rsp_rslt_q;
    rsp_sc_d    = rsp_sc_q;
    rsp_pari_d  = rsp_pari_q;
    rsp_one_d   = rsp_one_q;
    if (xfer) begin
      rsp_rslt_d = alu_rslt;
      rsp_sc_d   = alu_sc_o;
      rsp_pari_d = alu_pari;
      rsp_one_d  = alu_one;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      wd_q        <= '0;
      rsp_valid_q <= '0;
      rsp_rslt_q  <= '0;
      rsp_sc_q    <= 1'b0;
      rsp_pari_q  <= 1'b0;
      rsp_one_q   <= 1'b0;
      alu_cmd_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rslt_q  <= rsp_rslt_d;
      rsp_sc_q    <= rsp_sc_d;
      rsp_pari_q  <= rsp_pari_d;
      rsp_one_q   <= rsp_one_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sc_q    <= alu_sc_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, so a pending response
  // or lock indication never leaks out during reset.
  assign req_ready  = grant;
  assign alu_cmd    = reset ? 4'd0 : alu_cmd_d;
  assign alu_inA    = reset ? 8'd0 : alu_a_d;
  assign alu_inB    = reset ? 8'd0 : alu_b_d;
  assign alu_sc_i   = reset ? 1'b0 : alu_sc_d;
  assign rsp_valid  = reset ? '0   : rsp_valid_q;
  assign rsp_rslt   = reset ? 8'd0 : rsp_rslt_q;
  assign rsp_sc     = reset ? 1'b0 : rsp_sc_q;
  assign rsp_pari   = reset ? 1'b0 : rsp_pari_q;
  assign rsp_one    = reset ? 1'b0 : rsp_one_q;
  assign lock_owner = (reset || state_q == UNLOCKED) ? '0 : {owner_q, ~owner_q};

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_alu_arbiter;
  localparam int LOCK_MAX = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_LT  = 4'd14;
  localparam logic [3:0] OP_EQ  = 4'd15;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_ready, req_lock;
  logic [3:0] req_cmd0, req_cmd1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic       req_sc0, req_sc1;
  logic [3:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB;
  logic       alu_sc_i;
  logic [7:0] alu_rslt;
  logic       alu_sc_o, alu_pari, alu_one;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_rslt;
  logic       rsp_sc, rsp_pari, rsp_one;
  logic [1:0] lock_owner;

  logic [3:0] op_cmd [2];
  logic [7:0] op_a   [2];
  logic [7:0] op_b   [2];
  logic       op_sc  [2];

  assign req_cmd0 = op_cmd[0];
  assign req_cmd1 = op_cmd[1];
  assign req_a0   = op_a[0];
  assign req_a1   = op_a[1];
  assign req_b0   = op_b[0];
  assign req_b1   = op_b[1];
  assign req_sc0  = op_sc[0];
  assign req_sc1  = op_sc[1];

  int checks = 0;
  int errors = 0;
  logic [1:0] last_ready;

  // Model state
  bit         m_locked;
  int         m_owner, m_rr, m_wd;
  logic [3:0] m_hcmd;
  logic [7:0] m_ha, m_hb;
  logic       m_hsc;
  logic [1:0] m_rv;
  logic [7:0] m_rslt;
  logic       m_sc, m_pari, m_one;
  logic [3:0] m_rcmd;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2), .LOCK_MAX(LOCK_MAX), .CW(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_sc0(req_sc0), .req_sc1(req_sc1),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_pari(alu_pari), .alu_one(alu_one),
    .rsp_valid(rsp_valid), .rsp_rslt(rsp_rslt), .rsp_sc(rsp_sc),
    .rsp_pari(rsp_pari), .rsp_one(rsp_one), .lock_owner(lock_owner)
  );

  // ALU behaviour: returns {carry, parity, one, result}.
  function automatic logic [10:0] alu_ref(input logic [3:0] c, input logic [7:0] a,
                                          input logic [7:0] b, input logic s);
    logic [8:0] w;
    logic       one;
    one = 1'b0;
    case (c)
      4'd0:  w = {1'b0, a} + {1'b0, b};
      4'd1:  w = {1'b0, a} + {1'b0, b} + {8'd0, s};
      4'd2:  w = {1'b0, a} - {1'b0, b};
      4'd3:  w = {1'b0, a} - {1'b0, b} - {8'd0, s};
      4'd4:  w = {1'b0, a & b};
      4'd5:  w = {1'b0, a | b};
      4'd6:  w = {1'b0, a ^ b};
      4'd7:  w = {a, s};
      4'd8:  w = {a[0], s, a[7:1]};
      4'd9:  w = {1'b0, ~a};
      4'd10: w = {1'b0, a};
      4'd11: w = {1'b0, b};
      4'd12: w = {1'b0, a} + 9'd1;
      4'd13: w = {1'b0, a} - 9'd1;
      4'd14: begin w = {8'd0, a < b};  one = (a < b);  end
      default: begin w = {8'd0, a == b}; one = (a == b); end
    endcase
    return {w[8], ^w[7:0], one, w[7:0]};
  endfunction

  always_comb {alu_sc_o, alu_pari, alu_one, alu_rslt} = alu_ref(alu_cmd, alu_inA, alu_inB, alu_sc_i);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Who the rules say gets the ALU this cycle (-1 = nobody).
  function automatic int model_grant();
    if (reset) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    if (req_valid == 2'b11) return m_rr;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_wd = 0;
    m_hcmd = '0; m_ha = '0; m_hb = '0; m_hsc = 1'b0;
    m_rv = '0; m_rslt = '0; m_sc = 1'b0; m_pari = 1'b0; m_one = 1'b0; m_rcmd = '0;
  endtask

  // One clock: check everything visible before the edge, then advance the model.
  task automatic cycle();
    int         g;
    logic [1:0] exp_ready, exp_lo;
    logic [3:0] ec;
    logic [7:0] ea, eb;
    logic       es;
    bit         own_xfer;
    #2;
    g = model_grant();
    exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
    if (reset) begin
      ec = '0; ea = '0; eb = '0; es = 1'b0;
    end else if (g >= 0) begin
      ec = op_cmd[g]; ea = op_a[g]; eb = op_b[g]; es = op_sc[g];
    end else begin
      ec = m_hcmd; ea = m_ha; eb = m_hb; es = m_hsc;
    end
    exp_lo = (reset || !m_locked) ? 2'b00 : 2'(1 << m_owner);
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("alu_cmd", 32'(alu_cmd), 32'(ec));
    chk("alu_inA", 32'(alu_inA), 32'(ea));
    chk("alu_inB", 32'(alu_inB), 32'(eb));
    chk("alu_sc_i", 32'(alu_sc_i), 32'(es));
    chk("lock_owner", 32'(lock_owner), 32'(exp_lo));
    if (reset) begin
      chk("rsp_valid_rst", 32'(rsp_valid), 0);
      chk("rsp_rslt_rst", 32'(rsp_rslt), 0);
      chk("rsp_one_rst", 32'(rsp_one), 0);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_rslt", 32'(rsp_rslt), 32'(m_rslt));
      chk("rsp_sc", 32'(rsp_sc), 32'(m_sc));
      chk("rsp_pari", 32'(rsp_pari), 32'(m_pari));
      if (m_rcmd == OP_LT || m_rcmd == OP_EQ) chk("rsp_one", 32'(rsp_one), 32'(m_one));
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        {m_sc, m_pari, m_one, m_rslt} = alu_ref(op_cmd[g], op_a[g], op_b[g], op_sc[g]);
        m_rv = 2'(1 << g);
        m_rcmd = op_cmd[g];
        m_hcmd = op_cmd[g]; m_ha = op_a[g]; m_hb = op_b[g]; m_hsc = op_sc[g];
        m_rr = 1 - g;
      end else begin
        m_rv = 2'b00;
      end
      if (!m_locked) begin
        if (g >= 0 && req_lock[g]) begin
          m_locked = 1; m_owner = g; m_wd = 0;
        end
      end else begin
        own_xfer = (g == m_owner);
        if (m_wd == LOCK_MAX - 1) begin
          m_locked = 0; m_rr = 1 - m_owner;
        end else if ((own_xfer && !req_lock[m_owner]) ||
                     (!req_valid[m_owner] && !req_lock[m_owner])) begin
          m_locked = 0;
        end else begin
          m_wd++;
        end
      end
    end
    #1;
  endtask

  task automatic set_op(input int id, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic s);
    op_cmd[id] = c; op_a[id] = a; op_b[id] = b; op_sc[id] = s;
  endtask

  initial begin
    model_reset();
    reset = 1'b1; req_valid = 2'b00; req_lock = 2'b00;
    set_op(0, 4'd0, 8'd0, 8'd0, 1'b0);
    set_op(1, 4'd0, 8'd0, 8'd0, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rst_lock_owner", 32'(lock_owner), 0);

    // Single requester add with wrap-around.
    set_op(0, OP_ADD, 8'd200, 8'd100, 1'b0);
    req_valid = 2'b01;
    cycle();
    chk("tp1_ready", 32'(last_ready), 32'h1);
    chk("tp1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tp1_rslt", 32'(rsp_rslt), 44);
    req_valid = 2'b00;
    cycle();
    chk("tp1_rsp_drop", 32'(rsp_valid), 0);
    chk("tp1_rslt_hold", 32'(rsp_rslt), 44);

    // Contention after a fresh reset: grants alternate starting at req0.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_op(0, OP_SUB, 8'd9, 8'd4, 1'b0);
    set_op(1, OP_XOR, 8'hF0, 8'h0F, 1'b0);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("tp2_grant", 32'(last_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("tp2_rslt", 32'(rsp_rslt), (i % 2 == 0) ? 5 : 32'hFF);
    end

    // Lock chain from req1 while req0 keeps asking.
    set_op(1, OP_ADD, 8'hFF, 8'h01, 1'b0);
    req_lock = 2'b10;
    cycle();
    chk("tp3_ready0", 32'(last_ready), 32'h2);
    chk("tp3_owner0", 32'(lock_owner), 32'h2);
    set_op(1, OP_ADC, 8'h12, 8'h34, 1'b1);
    cycle();
    chk("tp3_ready1", 32'(last_ready), 32'h2);
    chk("tp3_owner1", 32'(lock_owner), 32'h2);
    req_lock = 2'b00;
    cycle();
    chk("tp3_ready2", 32'(last_ready), 32'h2);
    chk("tp3_unlocked", 32'(lock_owner), 0);
    cycle();
    chk("tp3_req0_next", 32'(last_ready), 32'h1);

    // Hand priority back to req0, then let it hog the lock.
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b11;
    req_lock = 2'b01;
    set_op(0, OP_ADC, 8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("tp4_ready", 32'(last_ready), (i == 17) ? 32'h2 : 32'h1);
    end

    // Compare ops drive the one flag.
    req_valid = 2'b01;
    req_lock = 2'b00;
    set_op(0, OP_LT, 8'd3, 8'd7, 1'b0);
    cycle();
    chk("tp5_lt_rslt", 32'(rsp_rslt), 1);
    chk("tp5_lt_one", 32'(rsp_one), 1);
    set_op(0, OP_EQ, 8'd5, 8'd6, 1'b0);
    cycle();
    chk("tp5_eq_rslt", 32'(rsp_rslt), 0);
    chk("tp5_eq_one", 32'(rsp_one), 0);

    // Reset right after a locking transfer from req1.
    req_valid = 2'b10;
    req_lock = 2'b10;
    set_op(1, OP_SUB, 8'd1, 8'd2, 1'b0);
    cycle();
    reset = 1'b1;
    req_valid = 2'b00;
    req_lock = 2'b00;
    cycle();
    reset = 1'b0;
    chk("tp6_rsp_dropped", 32'(rsp_valid), 0);
    chk("tp6_lock_cleared", 32'(lock_owner), 0);
    req_valid = 2'b11;
    cycle();
    chk("tp6_req0_first", 32'(last_ready), 32'h1);

    // Random traffic with sticky locks so the watchdog fires now and then.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      req_valid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        req_lock[r] = ($urandom_range(0, 9) < 8);
        set_op(r, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)));
      end
      cycle();
    end

    req_valid = 2'b00;
    req_lock = 2'b00;
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
